// File: rtl/lfsr_stream_cipher.sv
// Purpose   : byte stream cipher (XOR with a shift LFSR, parity in the MSB); encrypt, decrypt, or decrypt with key discovery.
// Latency   : 1 cycle from input accept to out_valid (registered output stage).
// Backpress.: in_ready drops while the output register is full and out_ready is low; held output stays stable.
// Ports     : clk/init_n; command req/mode/key_ptrn/key_init/msg_len; input stream in_valid/in_ready/in_data;
//             output stream out_valid/out_ready/out_data/out_perr; status busy/ack;
//             discovery results key_ok/key_fail/ptrn_idx/init_found.
module lfsr_stream_cipher #(
   parameter int                  LW    = 7,
   parameter int                  NPTRN = 9,
   parameter logic [NPTRN*LW-1:0] PTRNS = {7'h7B, 7'h7E, 7'h5C, 7'h69, 7'h6A, 7'h72, 7'h78, 7'h48, 7'h60},
   parameter logic [LW:0]         PAD   = 8'h20,
   parameter int                  NPRE  = 10,
   parameter int                  LEN_W = 7
) (
   input  logic             clk,
   input  logic             init_n,
   input  logic             req,
   input  logic [1:0]       mode,
   input  logic [LW-1:0]    key_ptrn,
   input  logic [LW-1:0]    key_init,
   input  logic [LEN_W-1:0] msg_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [LW:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LW:0]      out_data,
   output logic             out_perr,
   output logic             busy,
   output logic             ack,
   output logic             key_ok,
   output logic             key_fail,
   output logic [3:0]       ptrn_idx,
   output logic [LW-1:0]    init_found
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

   state_t           state, state_nxt;

   logic             dec;     // decrypt modes (01, 10, 11)
   logic             disc;    // discovery preamble still being evaluated
   logic [LW-1:0]    ptrn;
   logic [LW-1:0]    lfsr;    // state for the next byte; holds the start state during discovery
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] cnt;
   logic [LW-1:0]    cand [NPTRN];
   logic [NPTRN-1:0] mask;

   logic             accept;
   logic             last_byte;
   logic             first_disc;
   logic             last_disc;
   logic [LW-1:0]    derived;
   logic [LW-1:0]    start_st;
   logic [LW-1:0]    cand_nxt [NPTRN];
   logic [NPTRN-1:0] mask_nxt;
   logic [NPTRN-1:0] mask_eval;
   logic [3:0]       sel_idx;
   logic [LW-1:0]    sel_ptrn;
   logic [LW-1:0]    sel_next;
   logic [LW-1:0]    sel_state;
   logic [LW-1:0]    low;
   logic [LW:0]      dat_nxt;
   logic             perr_nxt;

   function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] s, input logic [LW-1:0] p);
      return {s[LW-2:0], ^(s & p)};
   endfunction

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) state <= IDLE;
      else         state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = (msg_len == '0) ? DONE : RUN;
         RUN:     if (accept && last_byte) state_nxt = DRAIN;
         DRAIN:   if (!out_valid) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready = (state == RUN) && (!out_valid || out_ready);
      busy     = (state != IDLE);
      ack      = (state == DONE);
   end

   assign accept    = in_valid && in_ready;
   assign last_byte = (cnt == len - LEN_W'(1));

   // ---------------- byte datapath ----------------
   always_comb begin
      derived    = in_data[LW-1:0] ^ PAD[LW-1:0];
      start_st   = (derived == '0) ? LW'(1) : derived;
      first_disc = disc && (cnt == '0);
      // short messages end discovery at their last byte
      last_disc  = disc && ((cnt == LEN_W'(NPRE - 1)) || last_byte);

      mask_nxt = '0;
      for (int k = 0; k < NPTRN; k++) begin
         cand_nxt[k] = lfsr_step(cand[k], PTRNS[k*LW +: LW]);
         mask_nxt[k] = mask[k] && (cand_nxt[k] == derived);
      end
      mask_eval = first_disc ? '1 : mask_nxt;

      // lowest surviving candidate; candidate 0 when nothing survives
      sel_idx  = '0;
      sel_ptrn = PTRNS[LW-1:0];
      sel_next = cand_nxt[0];
      for (int k = NPTRN - 1; k >= 0; k--) begin
         if (mask_eval[k]) begin
            sel_idx  = 4'(k);
            sel_ptrn = PTRNS[k*LW +: LW];
            sel_next = cand_nxt[k];
         end
      end

      if (!disc)          sel_state = lfsr;
      else if (first_disc) sel_state = start_st;
      else                sel_state = sel_next;

      low = in_data[LW-1:0] ^ sel_state;
      if (dec) begin
         dat_nxt  = {1'b0, low};
         perr_nxt = ^in_data;
      end else begin
         dat_nxt  = {^low, low};
         perr_nxt = 1'b0;
      end
   end

   // ---------------- key / discovery state ----------------
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         dec        <= 1'b0;
         disc       <= 1'b0;
         ptrn       <= '0;
         lfsr       <= '0;
         len        <= '0;
         cnt        <= '0;
         mask       <= '0;
         for (int k = 0; k < NPTRN; k++) cand[k] <= '0;
         key_ok     <= 1'b0;
         key_fail   <= 1'b0;
         ptrn_idx   <= '0;
         init_found <= '0;
      end else if (state == IDLE && req) begin
         dec        <= (mode != 2'b00);
         disc       <= (mode == 2'b10);
         ptrn       <= key_ptrn;
         lfsr       <= (key_init == '0) ? LW'(1) : key_init;
         len        <= msg_len;
         cnt        <= '0;
         mask       <= '0;
         key_ok     <= 1'b0;
         key_fail   <= 1'b0;
         ptrn_idx   <= '0;
         init_found <= '0;
      end else if (accept) begin
         if (!last_byte) cnt <= cnt + LEN_W'(1);
         if (disc) begin
            for (int k = 0; k < NPTRN; k++) cand[k] <= first_disc ? start_st : cand_nxt[k];
            mask <= first_disc ? '1 : mask_nxt;
            if (first_disc) lfsr <= start_st;
            if (first_disc && derived == '0) key_fail <= 1'b1;
            if (last_disc) begin
               // hand the winning candidate over to the plain decrypt path
               disc       <= 1'b0;
               key_ok     <= ($countones(mask_eval) == 1);
               key_fail   <= key_fail | (first_disc && derived == '0) | (mask_eval == '0);
               ptrn_idx   <= sel_idx;
               init_found <= first_disc ? start_st : lfsr;
               lfsr       <= lfsr_step(sel_state, sel_ptrn);
               ptrn       <= sel_ptrn;
            end
         end else begin
            lfsr <= lfsr_step(lfsr, ptrn);
         end
      end
   end

   // ---------------- output register ----------------
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_perr  <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= dat_nxt;
         out_perr  <= perr_nxt;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
